// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_sequencer
// Function : Multi-byte push/pull sequencer for a page-1 stack with 8-bit SP.
// Revision : 1.0
// ============================================================================
module stack_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sp_load,
    input  logic [7:0]  sp_load_data,
    input  logic        start,
    input  logic        dir,
    input  logic [1:0]  count,
    input  logic [23:0] push_data,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] addr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [7:0]  wdata,
    output logic [7:0]  sp,
    output logic [23:0] pull_data,
    output logic        busy,
    output logic        done,
    output logic        wrap
);

    localparam logic [7:0] STACK_PAGE = 8'h01;
    localparam logic [7:0] SP_RESET   = 8'hFD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        PULL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  idx;
    logic [1:0]  idx_inc;
    logic [23:0] push_buf;
    logic [7:0]  sp_inc;
    logic [7:0]  push_byte;
    logic        last_xfer;
    logic        accept;

    assign idx_inc   = idx + 2'd1;
    assign sp_inc    = sp + 8'd1;
    assign last_xfer = (idx_inc == cnt);
    // sp_load wins over start in the same cycle
    assign accept    = (state == IDLE) && !sp_load && start && (count != 2'd0);

    always_comb begin
        case (idx)
            2'd0:    push_byte = push_buf[7:0];
            2'd1:    push_byte = push_buf[15:8];
            default: push_byte = push_buf[23:16];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr      = 16'h0000;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wdata     = 8'h00;
        done      = 1'b0;
        wrap      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dir ? PULL : PUSH;
                end
            end
            PUSH: begin
                addr  = {STACK_PAGE, sp};
                wr_en = 1'b1;
                wdata = push_byte;
                wrap  = (sp == 8'h00);
                if (last_xfer) begin
                    state_nxt = DONE;
                end
            end
            PULL: begin
                addr  = {STACK_PAGE, sp_inc};
                rd_en = 1'b1;
                wrap  = (sp == 8'hFF);
                if (last_xfer) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp        <= SP_RESET;
            cnt       <= 2'd0;
            idx       <= 2'd0;
            push_buf  <= 24'h000000;
            pull_data <= 24'h000000;
        end else begin
            case (state)
                IDLE: begin
                    if (sp_load) begin
                        sp <= sp_load_data;
                    end else if (accept) begin
                        cnt      <= count;
                        idx      <= 2'd0;
                        push_buf <= push_data;
                        // unwritten slots of a new pull read back as zero
                        if (dir) begin
                            pull_data <= 24'h000000;
                        end
                    end
                end
                PUSH: begin
                    sp  <= sp - 8'd1;
                    idx <= idx_inc;
                end
                PULL: begin
                    sp  <= sp_inc;
                    idx <= idx_inc;
                    case (idx)
                        2'd0:    pull_data[7:0]   <= bus_rdata;
                        2'd1:    pull_data[15:8]  <= bus_rdata;
                        default: pull_data[23:16] <= bus_rdata;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_sequencer
// Function : Directed self-checking bench for stack_sequencer.
// Revision : 1.0
// ============================================================================
module tb_stack_sequencer;

    logic        clk;
    logic        reset_n;
    logic        sp_load;
    logic [7:0]  sp_load_data;
    logic        start;
    logic        dir;
    logic [1:0]  count;
    logic [23:0] push_data;
    logic [7:0]  bus_rdata;
    logic [15:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  wdata;
    logic [7:0]  sp;
    logic [23:0] pull_data;
    logic        busy;
    logic        done;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int wr_base;

    stack_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sp_load      (sp_load),
        .sp_load_data (sp_load_data),
        .start        (start),
        .dir          (dir),
        .count        (count),
        .push_data    (push_data),
        .bus_rdata    (bus_rdata),
        .addr         (addr),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wdata        (wdata),
        .sp           (sp),
        .pull_data    (pull_data),
        .busy         (busy),
        .done         (done),
        .wrap         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack memory contents used by the pull sequences
    always_comb begin
        case (addr)
            16'h01FE: bus_rdata = 8'h11;
            16'h01FF: bus_rdata = 8'h22;
            16'h0100: bus_rdata = 8'h33;
            default:  bus_rdata = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (wr_en) wr_count <= wr_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_sp(input logic [7:0] v);
        sp_load      = 1'b1;
        sp_load_data = v;
        step();
        sp_load      = 1'b0;
    endtask

    task automatic kick(input logic d, input logic [1:0] c, input logic [23:0] pd);
        start     = 1'b1;
        dir       = d;
        count     = c;
        push_data = pd;
        step();
        start     = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        sp_load      = 1'b0;
        sp_load_data = 8'h00;
        start        = 1'b0;
        dir          = 1'b0;
        count        = 2'd0;
        push_data    = 24'h0;
        #12;
        chk("rst_sp", 32'(sp), 32'hFD);
        chk("rst_busy", 32'(busy), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        chk("idle_sp", 32'(sp), 32'hFD);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_strobes", {30'h0, wr_en, rd_en}, 32'h0);
        chk("idle_addr", 32'(addr), 32'h0000);
        chk("idle_pull", 32'(pull_data), 32'h0);

        // Two-byte push from SP=10
        load_sp(8'h10);
        chk("load_sp", 32'(sp), 32'h10);
        kick(1'b0, 2'd2, 24'h00ABCD);
        chk("push1_addr", 32'(addr), 32'h0110);
        chk("push1_wdata", 32'(wdata), 32'hCD);
        chk("push1_str", {30'h0, wr_en, rd_en}, 32'h2);
        chk("push1_busy", 32'(busy), 32'h1);
        step();
        chk("push2_addr", 32'(addr), 32'h010F);
        chk("push2_wdata", 32'(wdata), 32'hAB);
        step();
        chk("push_done", 32'(done), 32'h1);
        chk("push_sp", 32'(sp), 32'h0E);
        chk("push_done_wr", 32'(wr_en), 32'h0);
        chk("push_done_wd", 32'(wdata), 32'h00);
        chk("push_done_busy", 32'(busy), 32'h1);
        step();
        chk("push_idle_done", 32'(done), 32'h0);
        chk("push_idle_busy", 32'(busy), 32'h0);

        // Push wrap 00 -> FF
        load_sp(8'h00);
        kick(1'b0, 2'd1, 24'h000055);
        chk("wrap_addr", 32'(addr), 32'h0100);
        chk("wrap_wdata", 32'(wdata), 32'h55);
        chk("wrap_push", 32'(wrap), 32'h1);
        step();
        chk("wrap_sp", 32'(sp), 32'hFF);
        chk("wrap_clear", 32'(wrap), 32'h0);
        chk("wrap_done", 32'(done), 32'h1);
        step();

        // Three-byte pull from SP=FD, wrapping FF -> 00
        load_sp(8'hFD);
        kick(1'b1, 2'd3, 24'h0);
        chk("pull1_addr", 32'(addr), 32'h01FE);
        chk("pull1_str", {30'h0, wr_en, rd_en}, 32'h1);
        chk("pull1_wrap", 32'(wrap), 32'h0);
        step();
        chk("pull2_addr", 32'(addr), 32'h01FF);
        chk("pull2_sp", 32'(sp), 32'hFE);
        step();
        chk("pull3_addr", 32'(addr), 32'h0100);
        chk("pull3_wrap", 32'(wrap), 32'h1);
        step();
        chk("pull_done", 32'(done), 32'h1);
        chk("pull_sp", 32'(sp), 32'h00);
        chk("pull_data3", 32'(pull_data), 32'h332211);
        chk("pull_done_rd", 32'(rd_en), 32'h0);
        step();
        chk("pull_hold", 32'(pull_data), 32'h332211);

        // Single-byte pull clears upper slots
        load_sp(8'hFD);
        kick(1'b1, 2'd1, 24'h0);
        step();
        chk("pull1b_data", 32'(pull_data), 32'h000011);
        chk("pull1b_sp", 32'(sp), 32'hFE);
        step();

        // Reset during second cycle of a three-byte push
        wr_base = wr_count;
        kick(1'b0, 2'd3, 24'h030201);
        step();
        chk("rstmid_wr_pre", 32'(wr_en), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_wr", 32'(wr_en), 32'h0);
        chk("rstmid_sp", 32'(sp), 32'hFD);
        chk("rstmid_busy", 32'(busy), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("rstmid_writes", 32'(wr_count - wr_base), 32'd1);
        chk("rstmid_idle_wr", 32'(wr_en), 32'h0);

        // count=0 start is ignored
        kick(1'b0, 2'd0, 24'h0000EE);
        chk("cnt0_busy", 32'(busy), 32'h0);
        chk("cnt0_str", {30'h0, wr_en, rd_en}, 32'h0);
        chk("cnt0_sp", 32'(sp), 32'hFD);

        // start and sp_load while busy are ignored
        kick(1'b0, 2'd1, 24'h000077);
        start        = 1'b1;
        dir          = 1'b1;
        count        = 2'd3;
        sp_load      = 1'b1;
        sp_load_data = 8'h44;
        step();
        chk("busy_done", 32'(done), 32'h1);
        chk("busy_sp", 32'(sp), 32'hFC);
        start   = 1'b0;
        sp_load = 1'b0;
        step();
        chk("busy_idle", 32'(busy), 32'h0);
        chk("busy_sp2", 32'(sp), 32'hFC);
        chk("busy_str", {30'h0, wr_en, rd_en}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have no parameters; stack page fixed at 8'h01, SP width fixed at 8 bits.
REQ-002 SHALL provide the following ports (name  direction  width  meaning):
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sp_load  input  1  load SP from sp_load_data (accepted in IDLE only).
REQ-006 sp_load_data  input  8  new SP value.
REQ-007 start  input  1  begin a stack sequence (accepted in IDLE only).
REQ-008 dir  input  1  0 = push (post-decrement), 1 = pull (pre-increment); sampled with start.
REQ-009 count  input  2  bytes to transfer, 1..3; sampled with start.
REQ-010 push_data  input  24  push bytes; [7:0] pushed first, then [15:8], then [23:16].
REQ-011 bus_rdata  input  8  stack read data, valid in the same cycle as rd_en.
REQ-012 addr  output  16  stack address {8'h01, pointer}.
REQ-013 wr_en / rd_en  output  1 each  stack write / read strobe.
REQ-014 wdata  output  8  byte being pushed.
REQ-015 sp  output  8  current stack pointer.
REQ-016 pull_data  output  24  pulled bytes; first pulled byte in [7:0].
REQ-017 busy  output  1  high in PUSH, PULL, DONE.
REQ-018 done  output  1  one-cycle pulse after the last transfer.
REQ-019 wrap  output  1  one-cycle pulse when SP wraps (00->FF on push, FF->00 on pull).

Function
REQ-020 States SHALL be IDLE, PUSH, PULL, DONE.
REQ-021 In IDLE, sp_load=1 SHALL set sp <= sp_load_data next edge and SHALL take priority over start (start dropped that cycle).
REQ-022 In IDLE, start=1 with count!=0 SHALL latch dir, count, push_data, and enter PUSH (dir=0) or PULL (dir=1); count=0 SHALL be ignored.
REQ-023 start and sp_load outside IDLE SHALL be ignored; no queueing.
REQ-024 PUSH, each cycle: addr={01,sp}, wdata=next byte, wr_en=1; edge: sp <= sp-1 (mod 256).
REQ-025 PULL, each cycle: addr={01,sp+1 mod 256}, rd_en=1; edge: bus_rdata captured into the next pull_data byte slot, sp <= sp+1 (mod 256).
REQ-026 A sequence SHALL occupy exactly count consecutive transfer cycles, then one DONE cycle (done=1), then IDLE; total latency start-to-done = count+1 cycles.
REQ-027 wr_en and rd_en SHALL never be high together and SHALL be 0 outside PUSH/PULL.
REQ-028 wrap SHALL pulse in the cycle the transfer that causes the wrap is presented (sp=00 during push, sp=FF during pull).
REQ-029 pull_data slots not written by the current pull SHALL be cleared to 0 at start of a pull; pull_data SHALL hold after DONE until the next pull.
REQ-030 wdata SHALL be 8'h00 when wr_en=0.

Reset
REQ-031 reset_n low SHALL immediately (asynchronously) force IDLE, sp=8'hFD, pull_data=0, and addr, wdata, wr_en, rd_en, busy, done, wrap all 0.
REQ-032 Reset mid-sequence SHALL abandon it with no further strobes; operation resumes from IDLE after reset_n rises.

Verification
REQ-033 Release reset -> sp=FD, busy=0, wr_en=rd_en=0, addr=0000.
REQ-034 sp_load 8'h10; push count=2, push_data=24'h00ABCD -> cycle1 addr=0110 wdata=CD, cycle2 addr=010F wdata=AB, sp=0E, done pulse next cycle.
REQ-035 sp=00, push count=1 data=24'h000055 -> addr=0100 wdata=55 wrap=1, sp=FF afterwards.
REQ-036 sp=FD, pull count=3, memory 01FE=11, 01FF=22, 0100=33 -> rd addrs 01FE,01FF,0100, wrap on third, sp=00, pull_data=24'h332211.
REQ-037 reset_n low during second cycle of a count=3 push -> wr_en drops immediately, sp=FD, no third write.
REQ-038 start with count=0, and start while busy -> no strobes, sp unchanged, busy unaffected.
